// File: rtl/hack_rom_loader.sv
// Boot loader: parses a byte-stream frame of big-endian 16-bit Hack words into
// instruction ROM from address 0. Define ROM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module hack_rom_loader #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_written
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
`ifdef ROM_LOADER_CHECKSUM_EN
    CHK,
`endif
    RUN,
    ERR
  } state_t;

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHK;
`else
  localparam state_t END_STATE = RUN;
`endif

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic [7:0]        n_hi;
  logic [7:0]        data_hi;
  logic [15:0]       n_words;
  logic [15:0]       hdr_n;
  logic [ADDR_W-1:0] addr;
  logic              last_word;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_acc;
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_n     = {n_hi, in_data};
  assign last_word = (words_written + 16'd1) == n_words;

  always_ff @(posedge clk) begin
    if (reset) state <= HDR_HI;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      case (state)
        HDR_HI:  state_next = HDR_LO;
        HDR_LO: begin
          if (hdr_n > 16'd32768)  state_next = ERR;
          else if (hdr_n == 16'd0) state_next = END_STATE;
          else                     state_next = DATA_HI;
        end
        DATA_HI: state_next = DATA_LO;
        DATA_LO: state_next = last_word ? END_STATE : DATA_HI;
`ifdef ROM_LOADER_CHECKSUM_EN
        CHK:     state_next = (in_data == chk_acc) ? RUN : ERR;
`endif
        default: state_next = state;
      endcase
    end
  end

  // done waits for the final write strobe to drain so the CPU never starts mid-write
  always_comb begin
    in_ready  = (state != RUN) && (state != ERR);
    done      = (state == RUN) && !rom_we;
    cpu_reset = !done;
    error     = (state == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_hi          <= '0;
      data_hi       <= '0;
      n_words       <= '0;
      addr          <= '0;
      rom_we        <= 1'b0;
      rom_addr      <= '0;
      rom_wdata     <= '0;
      words_written <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      chk_acc       <= '0;
`endif
    end else begin
      rom_we <= 1'b0;
      if (accept) begin
        case (state)
          HDR_HI: n_hi <= in_data;
          HDR_LO: n_words <= hdr_n;
          DATA_HI: begin
            data_hi <= in_data;
`ifdef ROM_LOADER_CHECKSUM_EN
            chk_acc <= chk_acc ^ in_data;
`endif
          end
          DATA_LO: begin
            rom_we        <= 1'b1;
            rom_addr      <= addr;
            rom_wdata     <= {data_hi, in_data};
            addr          <= addr + ADDR_W'(1);
            words_written <= words_written + 16'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
            chk_acc       <= chk_acc ^ in_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/hack_rom_loader.md
# hack_rom_loader

Boot-time program loader sitting directly upstream of `student_computer`. It accepts a byte stream (host link, test bench or serial front end), assembles big-endian 16-bit Hack instructions, and writes them into instruction ROM from address 0. It holds the computer's `reset` high for the whole load, then releases it so execution starts at PC 0 on the freshly loaded program.

## Interface

Parameters:
- `ADDR_W`, 15: ROM address width (32768 words).
- `DATA_W`, 16: instruction width; fixed at 16 (two bytes per word).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; restarts the loader.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `rom_we`  out  1  one-cycle ROM write strobe.
- `rom_addr`  out  15  ROM write address.
- `rom_wdata`  out  16  ROM write data.
- `cpu_reset`  out  1  drives `student_computer.reset`; high while loading or on error.
- `done`  out  1  load finished successfully; sticky until `reset`.
- `error`  out  1  load aborted; sticky until `reset`.
- `words_written`  out  16  count of ROM words written this load.

## Operation

- Byte accepted on any edge where `in_valid && in_ready`.
- Frame: `N_hi`, `N_lo` (word count N, big-endian), then N words as `hi`, `lo` byte pairs, then a checksum byte if configured.
- States: `HDR_HI` → `HDR_LO` → `DATA_HI` ↔ `DATA_LO` → (`CHK`) → `RUN`; any state may go to `ERR`.
- `HDR_LO` accept: if N > 32768, go to `ERR`. If N = 0, go to `CHK` (when enabled) or `RUN`. Otherwise go to `DATA_HI`.
- `DATA_LO` accept: register the word `{hi, lo}` at the current address and increment the address. After the Nth word, go to `CHK` or `RUN`; otherwise go to `DATA_HI`.
- Address runs 0..N−1. With N = 32768 the last address is 0x7FFF; the address never wraps within a load.
- `RUN`: `in_ready`=0, `cpu_reset`=0, `done`=1. Further bytes are ignored and not accepted.
- `ERR`: `in_ready`=0, `cpu_reset`=1, `error`=1. No further ROM writes.
- `done` and `error` are never both 1.
- `reset` mid-load: return to `HDR_HI` and clear the address, counters and checksum. Words already written stay in ROM. The next header loads from address 0 again.

## Timing

- Reset values: state `HDR_HI`, `in_ready`=1, `rom_we`=0, `rom_addr`=0, `rom_wdata`=0, `cpu_reset`=1, `done`=0, `error`=0, `words_written`=0.
- `in_ready` is 1 in all loading states, so the loader accepts one byte per cycle back-to-back. Idle cycles (`in_valid`=0) never change state.
- `rom_we` is high for exactly the one cycle after the `DATA_LO` byte is accepted, with `rom_addr` and `rom_wdata` valid in that cycle.
- `words_written` increments on the same edge that raises `rom_we`.
- `RUN` entry, with no checksum:
  - N > 0: `done`↑ and `cpu_reset`↓ become visible the cycle after the final `rom_we` cycle.
  - N = 0: visible the cycle after `HDR_LO` is accepted.
- `RUN` or `ERR` entry from `CHK`: outputs update the cycle after the checksum byte is accepted.
- `ERR` entry from an oversize header: `error`↑ the cycle after `HDR_LO` is accepted.
- `reset` wins over any simultaneous byte acceptance or write.

## Configuration

- `ROM_LOADER_CHECKSUM_EN` defined:
  - The `CHK` state exists and the frame ends with one byte equal to the XOR of all data bytes (headers excluded; 0x00 when N = 0).
  - Match → `RUN`. Mismatch → `ERR`.
  - The ROM writes already made remain, but `cpu_reset` stays 1.
- Not defined: there is no `CHK` state and no checksum byte; the last data word leads directly to `RUN`.

## Test plan

- Bytes 00 02 12 34 AB CD, no checksum, back-to-back → writes (0, 0x1234) and (1, 0xABCD); `words_written`=2; `done`=1 and `cpu_reset`=0 one cycle after the second `rom_we`.
- With `ROM_LOADER_CHECKSUM_EN`, same stream + 0x40 → `done`=1. Same stream + 0x41 → `error`=1, `cpu_reset`=1, `done`=0, both writes still issued.
- Header 80 01 → `error`=1 one cycle after the second byte; no `rom_we` ever; `in_ready`=0 afterwards.
- Header 00 00 (+ 0x00 if checksum enabled) → `done`=1 with zero writes; subsequent `in_valid` bytes not accepted.
- Load 00 03 11 11 then assert `reset` for 1 cycle, then send 00 01 BE EF → after reset, first write is (0, 0xBEEF); `words_written`=1; `done`=1.
- Stream from the first test with random 0–3-cycle `in_valid` gaps → identical write sequence and final outputs.
